// File: rtl/ssd_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver: converter states,
// active-low segment patterns and the digit decoder.
package ssd_scan_driver_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } conv_state_e;

    localparam int unsigned NumDigits = 4;

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] Seg0     = 7'b0000001;
    localparam logic [6:0] Seg1     = 7'b1001111;
    localparam logic [6:0] Seg2     = 7'b0010010;
    localparam logic [6:0] Seg3     = 7'b0000110;
    localparam logic [6:0] Seg4     = 7'b1001100;
    localparam logic [6:0] Seg5     = 7'b0100100;
    localparam logic [6:0] Seg6     = 7'b0100000;
    localparam logic [6:0] Seg7     = 7'b0001111;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0000100;
    localparam logic [6:0] SegBlank = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = Seg0;
            4'd1:    seg = Seg1;
            4'd2:    seg = Seg2;
            4'd3:    seg = Seg3;
            4'd4:    seg = Seg4;
            4'd5:    seg = Seg5;
            4'd6:    seg = Seg6;
            4'd7:    seg = Seg7;
            4'd8:    seg = Seg8;
            4'd9:    seg = Seg9;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-and-adjust iteration per cycle,
// IDLE -> SHIFT (VAL_W cycles) -> DONE.
module ssd_scan_driver_bin2bcd_seq
    import ssd_scan_driver_pkg::*;
#(
    parameter int unsigned VAL_W = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VAL_W-1:0]       bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NumDigits-1:0] bcd
);

    localparam int unsigned CntW = $clog2(VAL_W + 1);

    conv_state_e            state_q;
    logic [VAL_W-1:0]       bin_q;
    logic [4*NumDigits-1:0] acc_q;
    logic [4*NumDigits-1:0] acc_adj;
    logic [CntW-1:0]        iter_q;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(NumDigits); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_q   <= bin;
                        acc_q   <= '0;
                        iter_q  <= CntW'(VAL_W);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
                    iter_q         <= iter_q - CntW'(1);
                    if (iter_q == CntW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign bcd  = acc_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed common-anode display driver with binary-to-BCD conversion.
// Optional leading-zero blanking via `SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned VAL_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [VAL_W-1:0] value,
    output logic [3:0]       anode,
    output logic [6:0]       seg,
    output logic             busy,
    output logic             bcd_valid
);

    logic [VAL_W-1:0]        last_value_q, last_value_d;
    logic [4*NumDigits-1:0]  digits_q, digits_d;
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]              anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    bcd_valid_q;
    logic [1:0]              sel_d;
    logic [3:0]              digit_d;
    logic                    blank_d;

    logic                   conv_start;
    logic                   conv_busy;
    logic                   conv_done;
    logic [4*NumDigits-1:0] conv_bcd;

    // Only compare while idle so a value change mid-conversion is picked up afterwards
    assign conv_start = !conv_busy && (value != last_value_q);

    ssd_scan_driver_bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Anode and segments are derived from next-state counter/digits so the registered
    // outputs always match the current counter position.
    always_comb begin
        last_value_d = conv_start ? value : last_value_q;
        digits_d     = conv_done ? conv_bcd : digits_q;
        cnt_d        = cnt_q + REFRESH_BITS'(1);
        sel_d        = cnt_d[REFRESH_BITS-1 -: 2];
        digit_d      = digits_d[{sel_d, 2'b00} +: 4];
        blank_d      = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        case (sel_d)
            2'd1:    blank_d = (digits_d[15:4] == '0);
            2'd2:    blank_d = (digits_d[15:8] == '0);
            2'd3:    blank_d = (digits_d[15:12] == '0);
            default: blank_d = 1'b0;
        endcase
`endif
        seg_d   = blank_d ? SegBlank : seg_decode(digit_d);
        anode_d = en ? ~(4'b0001 << sel_d) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_value_q <= '0;
            digits_q     <= '0;
            cnt_q        <= '0;
            anode_q      <= 4'b1110;
            seg_q        <= Seg0;
            bcd_valid_q  <= 1'b0;
        end else begin
            last_value_q <= last_value_d;
            digits_q     <= digits_d;
            cnt_q        <= cnt_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            bcd_valid_q  <= conv_done;
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign busy      = conv_busy;
    assign bcd_valid = bcd_valid_q;

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumer end of the datapath's 13-bit seven-segment debug bus (`ssd` output), which drives a 4-digit multiplexed common-anode display.
- Converts the unsigned binary value (0..8191) to 4 BCD digits with a sequential double-dabble engine.
- Scans the digits with a refresh counter and drives active-low anode and segment lines.
- Sits at board top level between the DataPath `ssd` output and the FPGA display pins.

Parameters:
- REFRESH_BITS, 18, refresh counter width. The top 2 bits select the active digit. The bench uses 4.
- VAL_W, 13, input value width. Fixed at 13 to match the datapath bus; 4 BCD digits cover the maximum, 8191.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable. When 0, all anodes are off.
- value  in  13  binary value to display.
- anode  out  4  active-low digit enables. anode[0] is the ones digit.
- seg  out  7  active-low segments, order {a,b,c,d,e,f,g}; seg[6]=a.
- busy  out  1  high while a conversion is in progress.
- bcd_valid  out  1  one-cycle pulse when the displayed digits update.

Behaviour:
- Reset (rst sampled high) sets:
  - state=IDLE, refresh counter=0, last_value=0, display digits=0000.
  - busy=0, bcd_valid=0, anode=4'b1110, seg=7'b0000001 (digit "0").
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If value != last_value: latch value into the shift register and last_value, clear the BCD accumulator, load iteration count 13, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - One iteration per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - Decrement the iteration count. Go to DONE after the 13th iteration.
- DONE:
  - Copy the accumulator to the display digit registers.
  - bcd_valid=1 for exactly this cycle. Return to IDLE.
- Latency: for a change seen in IDLE at edge N:
  - busy=1 from after edge N until DONE completes.
  - SHIFT occupies edges N+1..N+13, DONE is N+14.
  - Display digits and the bcd_valid pulse take effect after edge N+14.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- value changes during SHIFT/DONE are ignored; the running conversion completes with the latched value. On return to IDLE the new value differs from last_value and triggers a fresh conversion. The display never shows a partial result.
- Reset mid-conversion aborts on the next edge: digits=0000, busy=0, no bcd_valid pulse.
- Refresh counter:
  - Free-running, wraps 2^REFRESH_BITS-1 -> 0. It runs regardless of en.
  - sel = counter[REFRESH_BITS-1 -: 2]. anode = ~(4'b0001 << sel) when en=1, 4'b1111 when en=0.
  - seg is the decode of digit[sel], registered in the same cycle as anode so both switch together.
- Segment decode (active-low), digits 0-9:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Any other nibble = 1111111 (unreachable; defensive only).

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined: digits 3..1 show seg=7'b1111111 while that digit and all higher digits are 0; the anode still cycles normally. Digit 0 is always shown. Example: 0 shows "   0"; 1050 is unaffected.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Shared defines header (defines.v) holds:
  - FSM state encodings (2-bit IDLE/SHIFT/DONE).
  - The 7-bit segment constants for 0-9 and blank.
  - The BCD digit count (4).
- One sub-module, bin2bcd_seq: the IDLE/SHIFT/DONE double-dabble engine, with ports clk, rst, start, bin[12:0], busy, done, bcd[15:0].
- ssd_scan_driver keeps last_value compare, display registers, refresh counter, anode/segment decode.

Test Plan (REFRESH_BITS=4, so 4 cycles per digit):
1. rst=1 for 2 cycles, value=0 -> anode=1110, seg=0000001, busy=0, bcd_valid=0. No conversion starts after rst drops.
2. value=1234 -> busy=1 for 14 cycles, bcd_valid pulses once. Scan then shows:
   - anode 1110 / seg 1001100 ("4")
   - anode 1101 / seg 0000110 ("3")
   - anode 1011 / seg 0010010 ("2")
   - anode 0111 / seg 1001111 ("1")
3. value=8191 -> digits 1, 9, 1, 8 on anodes 0..3. value=9 -> digits 9, 0, 0, 0 without the macro; "   9" with SSD_LEADING_ZERO_BLANK_EN.
4. value 1234 -> 5 changed at the 5th SHIFT cycle -> first bcd_valid pulse shows 1234, second conversion starts in IDLE, second pulse shows 0005. No intermediate digit pattern appears.
5. rst asserted for 1 cycle mid-SHIFT -> busy=0 and digits=0000 after that edge, no bcd_valid. With value still 1234 after rst drops, conversion restarts and completes.
6. en=0 for 20 cycles -> anode=1111 throughout, refresh counter keeps counting. When en returns to 1, anode follows the counter position (sel = counter[3:2]).
